rom_read_arbiter: RTL
=====================

Name: rom_read_arbiter

Overview:
- Shares one combinational 32-bit firmware ROM (N words, address in, data out) between NUM_REQ independent read requesters.
- Round-robin grant, one outstanding read at a time.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Sits between fetch/config clients and the ROM; drives the ROM address and registers the ROM data.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DEPTH, 64, ROM word count; must match the ROM's N.
- ADDR_W, $clog2(DEPTH), address width (derived, localparam).

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester read request.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_ready  output  NUM_REQ  request accepted (one-hot or zero).
- rsp_valid  output  NUM_REQ  response valid (one-hot or zero).
- rsp_data  output  32  read data; shared bus.
- rsp_ready  input  NUM_REQ  requester accepts response.
- rom_address  output  ADDR_W  to ROM address.
- rom_data  input  32  from ROM data_out.
- busy  output  1  high when state ≠ IDLE.
- grant_id  output  $clog2(NUM_REQ)  index of current/last granted requester.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; rr_ptr=0; grant_id=0; addr_q=0; data_q=0.
  - All req_ready/rsp_valid=0; rsp_data=0; rom_address=0; busy=0.
- FSM states: IDLE, READ, RESP.
- IDLE:
  - Grant g = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - If any request: req_ready[g]=1 combinationally that cycle; at the edge, addr_q←req_addr[g] and grant_id←g; go READ.
  - If no request: stay IDLE, req_ready=0.
- READ:
  - rom_address=addr_q (registered, glitch-free).
  - At the edge: data_q←rom_data; go RESP.
- RESP:
  - rsp_valid[grant_id]=1; rsp_data=data_q.
  - On rsp_ready[grant_id]=1: go IDLE; rr_ptr←(grant_id+1) mod NUM_REQ.
  - Otherwise hold rsp_valid and rsp_data stable indefinitely.
  - rsp_ready of non-granted requesters is ignored.
- Latency: request handshake at cycle T; rsp_valid asserted at T+2. Minimum 3 cycles per read, so peak throughput is 1 read per 3 cycles.
- req_ready is 0 in READ and RESP. req_valid that drops before grant is legal; no request is latched.
- rom_address holds addr_q in all states (0 after reset). rsp_data outside RESP = data_q, don't-care for clients.
- Simultaneous requests: strict round-robin, so no requester waits more than NUM_REQ−1 grants.
- Request arriving in the same cycle as rsp_ready: not granted until the next IDLE cycle (no bypass).
- Reset mid-operation: the transaction is discarded, no response is produced, and the requester must re-request.
- When NUM_REQ is not a power of two, the rr_ptr wrap goes to 0 after NUM_REQ−1.

Optional Feature:
- Macro: ROM_BOUNDS_CHECK_EN.
- Defined:
  - Adds output addr_err (1 bit, reset 0).
  - In IDLE, if the granted req_addr ≥ DEPTH (possible when DEPTH is not a power of two), the request is accepted normally.
  - In READ, data_q←32'hDEAD_BEEF instead of rom_data.
  - addr_err=1 for exactly the RESP cycles of that transaction.
- Not defined:
  - No addr_err port.
  - Out-of-range addresses pass straight to the ROM; the result is whatever the ROM mux returns.

Test Plan:
- Reset then single read: ROM word 5 = 32'h0000_0505; req_valid[0]=1, addr=5, rsp_ready[0]=1 → req_ready[0] at T, rsp_valid[0]=1 with rsp_data=32'h0000_0505 at T+2, busy high T+1..T+2, rr_ptr=1 afterwards.
- All four requesters valid continuously, addrs 10/11/12/13, rsp_ready all 1 → grants in order 0,1,2,3,0, one grant every 3 cycles, each response carries its own address's word.
- Backpressure: rsp_ready[2]=0 for 5 cycles → rsp_valid[2] and rsp_data held constant 5 cycles; req_ready stays 0 for all; completes on the cycle rsp_ready[2]=1.
- Fairness: req 1 and req 3 both held valid, rr_ptr=2 → req 3 granted first, then req 1.
- Async reset asserted during READ → all outputs 0 immediately (no clock edge needed); no rsp_valid after release; state IDLE.
- With ROM_BOUNDS_CHECK_EN and DEPTH=48: request addr 50 → rsp_data=32'hDEAD_BEEF, addr_err=1 during RESP; addr 47 → normal data, addr_err=0.

Source files
------------

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one combinational 32-bit ROM among NUM_REQ
// requesters, one read in flight. Optional ROM_BOUNDS_CHECK_EN adds addr_err.
`timescale 1ns/1ps
module rom_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 64,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [31:0]               rsp_data,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [31:0]               rom_data,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id
`ifdef ROM_BOUNDS_CHECK_EN
  ,
  output logic                      addr_err
`endif
);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     grant_id_q;
  logic [ID_W-1:0]     gnt_idx;
  logic                gnt_found;
  logic [ID_W-1:0]     ptr_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         data_q;
  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
  logic [ID_W:0]       scan_sum;
`ifdef ROM_BOUNDS_CHECK_EN
  logic                err_q;
  logic                gnt_oob;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
  end

  // Scan from rr_ptr upward with wrap at NUM_REQ; first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_sum  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (scan_sum >= (ID_W+1)'(NUM_REQ))
        scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
      if (!gnt_found && req_valid[scan_sum[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_sum[ID_W-1:0];
      end
    end
  end

  assign ptr_nxt = (grant_id_q == ID_W'(NUM_REQ-1)) ? '0 : grant_id_q + 1'b1;

`ifdef ROM_BOUNDS_CHECK_EN
  assign gnt_oob = ({1'b0, addr_arr[gnt_idx]} >= (ADDR_W+1)'(DEPTH));
`endif

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    case (state)
      IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          state_nxt          = READ;
        end
      end
      READ: state_nxt = RESP;
      RESP: begin
        rsp_valid[grant_id_q] = 1'b1;
        if (rsp_ready[grant_id_q])
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_id_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
`ifdef ROM_BOUNDS_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            addr_q     <= addr_arr[gnt_idx];
            grant_id_q <= gnt_idx;
`ifdef ROM_BOUNDS_CHECK_EN
            err_q      <= gnt_oob;
`endif
          end
        end
        READ: begin
`ifdef ROM_BOUNDS_CHECK_EN
          data_q <= err_q ? 32'hDEAD_BEEF : rom_data;
`else
          data_q <= rom_data;
`endif
        end
        RESP: begin
          if (rsp_ready[grant_id_q])
            rr_ptr <= ptr_nxt;
        end
        default: ;
      endcase
    end
  end

  assign rom_address = addr_q;
  assign rsp_data    = data_q;
  assign busy        = (state != IDLE);
  assign grant_id    = grant_id_q;
`ifdef ROM_BOUNDS_CHECK_EN
  assign addr_err    = (state == RESP) && err_q;
`endif

endmodule
